// File: rtl/pipeline_hazard_controller.sv
// Hazard / stall / flush controller for a 5-stage pipeline.
// Mealy outputs from a RUN / FLUSH / MEM_WAIT state machine plus stall and timeout tracking.
module pipeline_hazard_controller #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [5:0]  id_op,
  input  logic [4:0]  id_ra,
  input  logic [4:0]  id_rb,
  input  logic        ex_load,
  input  logic [4:0]  ex_rw,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_bubble,
  output logic        flush,
  output logic        mem_timeout,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  localparam int unsigned FCNT_W  = 3;
  localparam int unsigned WCNT_W  = 8;
  localparam int unsigned STALL_W = 16;

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_FLUSH    = 2'b01;
  localparam logic [1:0] ST_MEM_WAIT = 2'b10;

  logic [1:0]         r_state;
  logic [FCNT_W-1:0]  r_fcnt;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_mem_timeout;
  logic               r_to_done;

  logic [1:0]         w_next_state;
  logic [FCNT_W-1:0]  w_next_fcnt;
  logic [WCNT_W-1:0]  w_next_wcnt;
  logic               w_next_to_done;
  logic               w_fire;
  logic               w_imm;
  logic               w_hazard;

  // Immediate-format opcodes (001xxx) carry no rb operand.
  assign w_imm    = (id_op >= 6'b001000) && (id_op <= 6'b001111);
  assign w_hazard = id_valid && ex_load && (ex_rw != 5'd0) &&
                    ((ex_rw == id_ra) || ((ex_rw == id_rb) && !w_imm));

  always_comb begin
    w_next_state   = r_state;
    w_next_fcnt    = r_fcnt;
    w_next_wcnt    = r_wcnt;
    w_next_to_done = r_to_done;
    w_fire         = 1'b0;
    pc_en          = 1'b1;
    ifid_en        = 1'b1;
    idex_bubble    = 1'b0;
    flush          = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (branch_taken) begin
          flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_next_state = ST_FLUSH;
            w_next_fcnt  = FCNT_W'(FLUSH_CYCLES - 1);
          end
        end else if (mem_busy) begin
          pc_en          = 1'b0;
          ifid_en        = 1'b0;
          w_next_state   = ST_MEM_WAIT;
          w_next_wcnt    = WCNT_W'(1);
          w_next_to_done = 1'b0;
        end else if (w_hazard) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (mem_busy) begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
        end else if (r_fcnt <= FCNT_W'(1)) begin
          w_next_state = ST_RUN;
          w_next_fcnt  = '0;
        end else begin
          w_next_fcnt = r_fcnt - FCNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        // Timeout fires once per MEM_WAIT visit, even if the counter sits saturated.
        w_fire  = (r_wcnt == WCNT_W'(MEM_TIMEOUT)) && !r_to_done;
        if (w_fire) begin
          w_next_to_done = 1'b1;
        end
        if (mem_busy) begin
          if (r_wcnt != '1) begin
            w_next_wcnt = r_wcnt + WCNT_W'(1);
          end
        end else begin
          w_next_state = ST_RUN;
          w_next_wcnt  = '0;
        end
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_RUN;
      r_fcnt        <= '0;
      r_wcnt        <= '0;
      r_to_done     <= 1'b0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      r_state       <= w_next_state;
      r_fcnt        <= w_next_fcnt;
      r_wcnt        <= w_next_wcnt;
      r_to_done     <= w_next_to_done;
      r_mem_timeout <= w_fire;
      if (!pc_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_W'(1);
      end
    end
  end

  assign state       = r_state;
  assign mem_timeout = r_mem_timeout;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (FLUSH_CYCLES=2, MEM_TIMEOUT=3).
module tb_pipeline_hazard_controller;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [5:0]  id_op;
  logic [4:0]  id_ra;
  logic [4:0]  id_rb;
  logic        ex_load;
  logic [4:0]  ex_rw;
  logic        branch_taken;
  logic        mem_busy;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_bubble;
  logic        flush;
  logic        mem_timeout;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  int checks;
  int failures;

  pipeline_hazard_controller #(
    .FLUSH_CYCLES(2),
    .MEM_TIMEOUT (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_op       (id_op),
    .id_ra       (id_ra),
    .id_rb       (id_rb),
    .ex_load     (ex_load),
    .ex_rw       (ex_rw),
    .branch_taken(branch_taken),
    .mem_busy    (mem_busy),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_bubble (idex_bubble),
    .flush       (flush),
    .mem_timeout (mem_timeout),
    .state       (state),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    id_valid = 1'b0; id_op = 6'd0; id_ra = 5'd0; id_rb = 5'd0;
    ex_load = 1'b0; ex_rw = 5'd0; branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rw, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [5:0] op);
    id_valid = 1'b1; ex_load = 1'b1; ex_rw = rw; id_ra = ra; id_rb = rb; id_op = op;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    quiet();
    reset = 1'b0;
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd1);
    chk("rst_ifid_en", 32'(ifid_en), 32'd1);
    chk("rst_bubble", 32'(idex_bubble), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    reset = 1'b1;

    // Load-use on ra: single-cycle bubble
    load_use(5'd5, 5'd5, 5'd0, 6'b000000);
    #1;
    chk("lu_pc_en", 32'(pc_en), 32'd0);
    chk("lu_ifid_en", 32'(ifid_en), 32'd0);
    chk("lu_bubble", 32'(idex_bubble), 32'd1);
    tick();
    quiet();
    #1;
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_after_pc_en", 32'(pc_en), 32'd1);
    chk("lu_after_bubble", 32'(idex_bubble), 32'd0);

    // Immediate opcode ignores rb match; register opcode does not; r0 never hazards
    load_use(5'd7, 5'd3, 5'd7, 6'b001000);
    #1;
    chk("imm_pc_en", 32'(pc_en), 32'd1);
    chk("imm_bubble", 32'(idex_bubble), 32'd0);
    id_op = 6'b000000;
    #1;
    chk("rb_pc_en", 32'(pc_en), 32'd0);
    chk("rb_bubble", 32'(idex_bubble), 32'd1);
    load_use(5'd0, 5'd0, 5'd0, 6'b000000);
    #1;
    chk("r0_pc_en", 32'(pc_en), 32'd1);
    chk("r0_bubble", 32'(idex_bubble), 32'd0);
    tick();
    quiet();
    #1;
    chk("r0_stall_cnt", 32'(stall_cnt), 32'd1);

    // Taken branch: two flush cycles, second branch ignored
    branch_taken = 1'b1;
    #1;
    chk("br_flush0", 32'(flush), 32'd1);
    chk("br_pc_en0", 32'(pc_en), 32'd1);
    chk("br_state0", 32'(state), 32'd0);
    tick();
    #1;
    chk("br_state1", 32'(state), 32'd1);
    chk("br_flush1", 32'(flush), 32'd1);
    chk("br_pc_en1", 32'(pc_en), 32'd1);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("br_state2", 32'(state), 32'd0);
    chk("br_flush2", 32'(flush), 32'd0);
    tick();

    // Branch + mem_busy + hazard together: flush wins, busy freezes FLUSH
    branch_taken = 1'b1; mem_busy = 1'b1;
    load_use(5'd5, 5'd5, 5'd0, 6'b000000);
    #1;
    chk("sim_flush", 32'(flush), 32'd1);
    chk("sim_pc_en", 32'(pc_en), 32'd1);
    chk("sim_bubble", 32'(idex_bubble), 32'd0);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("simf_state", 32'(state), 32'd1);
    chk("simf_flush", 32'(flush), 32'd1);
    chk("simf_pc_en", 32'(pc_en), 32'd0);
    chk("simf_ifid_en", 32'(ifid_en), 32'd0);
    chk("simf_bubble", 32'(idex_bubble), 32'd0);
    tick();
    #1;
    chk("simf_hold_state", 32'(state), 32'd1);
    chk("simf_hold_flush", 32'(flush), 32'd1);
    tick();
    quiet();
    #1;
    chk("simf_last_state", 32'(state), 32'd1);
    chk("simf_last_flush", 32'(flush), 32'd1);
    chk("simf_last_pc_en", 32'(pc_en), 32'd1);
    tick();
    #1;
    chk("simf_done_state", 32'(state), 32'd0);
    chk("simf_done_flush", 32'(flush), 32'd0);
    chk("simf_stall_cnt", 32'(stall_cnt), 32'd3);

    // Mid-cycle reset clears counters immediately
    #2;
    reset = 1'b0;
    #1;
    chk("rst2_stall", 32'(stall_cnt), 32'd0);
    chk("rst2_state", 32'(state), 32'd0);
    reset = 1'b1;
    tick();

    // Memory wait: five busy cycles give six stalled cycles (entry + four waits + exit)
    mem_busy = 1'b1;
    #1;
    chk("mw_pc_en0", 32'(pc_en), 32'd0);
    chk("mw_state0", 32'(state), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 5) mem_busy = 1'b0;
      #1;
      chk($sformatf("mw_state%0d", i), 32'(state), 32'd2);
      chk($sformatf("mw_pc_en%0d", i), 32'(pc_en), 32'd0);
      chk($sformatf("mw_timeout%0d", i), 32'(mem_timeout), (i == 4) ? 32'd1 : 32'd0);
    end
    tick();
    #1;
    chk("mw_exit_state", 32'(state), 32'd0);
    chk("mw_exit_pc_en", 32'(pc_en), 32'd1);
    chk("mw_exit_timeout", 32'(mem_timeout), 32'd0);
    chk("mw_stall_cnt", 32'(stall_cnt), 32'd6);

    // Reset during MEM_WAIT aborts it; no later timeout pulse
    mem_busy = 1'b1;
    tick();
    tick();
    #1;
    chk("rmw_state_pre", 32'(state), 32'd2);
    #1;
    reset = 1'b0;
    mem_busy = 1'b0;
    #1;
    chk("rmw_state", 32'(state), 32'd0);
    chk("rmw_stall", 32'(stall_cnt), 32'd0);
    chk("rmw_pc_en", 32'(pc_en), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk($sformatf("rmw_timeout%0d", i), 32'(mem_timeout), 32'd0);
      chk($sformatf("rmw_idle_state%0d", i), 32'(state), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
